// File: rtl/store_arbiter.sv
// Per-channel store FIFOs serialised round-robin onto one memory write port; a push reaches wdata one edge later.
// The output register holds its word while mem_ready is low; a push into a full, non-popping channel is dropped and flagged.
module store_arbiter #(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int SEL_W  = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH-1:0]        store,
    input  logic [NUM_CH*DATA_W-1:0] data_in,
    input  logic                     mem_ready,
    output logic                     write,
    output logic [SEL_W-1:0]         select,
    output logic [DATA_W-1:0]        wdata,
    output logic [NUM_CH-1:0]        full,
    output logic [NUM_CH-1:0]        overflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [DATA_W-1:0] mem_q [NUM_CH][DEPTH];
    logic [CW-1:0]     count_q [NUM_CH];
    logic [CW-1:0]     count_d [NUM_CH];
    logic [PW-1:0]     wr_ptr_q [NUM_CH];
    logic [PW-1:0]     wr_ptr_d [NUM_CH];
    logic [PW-1:0]     rd_ptr_q [NUM_CH];
    logic [PW-1:0]     rd_ptr_d [NUM_CH];

    logic [IW-1:0]     rr_q, rr_d, grant_idx;
    logic              grant_vld, load;
    logic [NUM_CH-1:0] nonempty, pop, push_ok;
    logic [NUM_CH-1:0] ovf_q, ovf_d;

    logic              write_q, write_d;
    logic [SEL_W-1:0]  select_q, select_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    always_comb begin
        nonempty = '0;
        full     = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            nonempty[i] = (count_q[i] != '0);
            full[i]     = (count_q[i] == CW'(DEPTH));
        end
    end

    // First non-empty channel at or after rr_q, wrapping at NUM_CH.
    always_comb begin
        int c;
        c         = 0;
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            c = int'(rr_q) + k;
            if (c >= NUM_CH) c = c - NUM_CH;
            if (!grant_vld && nonempty[c]) begin
                grant_vld = 1'b1;
                grant_idx = IW'(c);
            end
        end
    end

    assign load = (!write_q || mem_ready) && grant_vld;

    always_comb begin
        pop     = '0;
        push_ok = '0;
        ovf_d   = ovf_q;
        for (int i = 0; i < NUM_CH; i++) begin
            pop[i]      = load && (grant_idx == IW'(i));
            push_ok[i]  = store[i] && ((count_q[i] != CW'(DEPTH)) || pop[i]);
            ovf_d[i]    = ovf_q[i] | (store[i] & ~push_ok[i]);
            count_d[i]  = count_q[i] + CW'(push_ok[i]) - CW'(pop[i]);
            wr_ptr_d[i] = wr_ptr_q[i] + PW'(push_ok[i]);
            rd_ptr_d[i] = rd_ptr_q[i] + PW'(pop[i]);
        end
    end

    always_comb begin
        write_d  = write_q;
        select_d = select_q;
        wdata_d  = wdata_q;
        rr_d     = rr_q;
        if (load) begin
            write_d  = 1'b1;
            select_d = SEL_W'(grant_idx) + SEL_W'(1);
            wdata_d  = mem_q[grant_idx][rd_ptr_q[grant_idx]];
            rr_d     = (grant_idx == IW'(NUM_CH - 1)) ? '0 : grant_idx + IW'(1);
        end else if (write_q && mem_ready) begin
            write_d  = 1'b0;
            select_d = '0;
        end
    end

    // Storage is not reset: emptied pointers make stale entries unreachable.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (push_ok[i]) mem_q[i][wr_ptr_q[i]] <= data_in[i*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                count_q[i]  <= '0;
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
            end
            rr_q     <= '0;
            ovf_q    <= '0;
            write_q  <= 1'b0;
            select_q <= '0;
            wdata_q  <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                count_q[i]  <= count_d[i];
                wr_ptr_q[i] <= wr_ptr_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
            end
            rr_q     <= rr_d;
            ovf_q    <= ovf_d;
            write_q  <= write_d;
            select_q <= select_d;
            wdata_q  <= wdata_d;
        end
    end

    assign write    = write_q;
    assign select   = select_q;
    assign wdata    = wdata_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_store_arbiter.sv
// Bench for store_arbiter: directed scenarios plus randomized traffic against a queue-based model.
module tb_store_arbiter;
    localparam int NCH = 3;
    localparam int DW  = 32;
    localparam int DEP = 4;
    localparam int SW  = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [NCH-1:0]    store;
    logic [NCH*DW-1:0] data_in;
    logic              mem_ready;
    logic              write;
    logic [SW-1:0]     select;
    logic [DW-1:0]     wdata;
    logic [NCH-1:0]    full;
    logic [NCH-1:0]    overflow;

    int checks = 0;
    int errors = 0;

    store_arbiter #(.NUM_CH(NCH), .DATA_W(DW), .DEPTH(DEP), .SEL_W(SW)) dut (
        .clk(clk), .reset(reset), .store(store), .data_in(data_in),
        .mem_ready(mem_ready), .write(write), .select(select), .wdata(wdata),
        .full(full), .overflow(overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish (checks=%0d)", checks);
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        store = '0; data_in = '0; mem_ready = 1'b0;
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic load_words(input int r);
        for (int c = 0; c < NCH; c++) data_in[c*DW +: DW] = 32'h100 * (c + 1) + r;
    endtask

    task automatic test_reset;
        store = '0; data_in = '0; mem_ready = 1'b0; reset = 1'b1;
        #1;
        checks++; if ({write, select, wdata, full, overflow} !== '0) begin errors++;
            $display("FAIL reset_async: got w=%b s=%0d d=%h f=%b o=%b expected all 0", write, select, wdata, full, overflow); end
        @(negedge clk); reset = 1'b0;
        for (int n = 0; n < 3; n++) begin
            tick();
            checks++; if ({write, select, wdata, full, overflow} !== '0) begin errors++;
                $display("FAIL reset_idle%0d: got w=%b s=%0d d=%h f=%b o=%b expected all 0", n, write, select, wdata, full, overflow); end
        end
    endtask

    task automatic test_two_channel(input bit backpressure);
        do_reset();
        mem_ready = 1'b1;
        store = 3'b011;
        data_in = '0; data_in[DW-1:0] = 32'h11111111; data_in[DW +: DW] = 32'h22222222;
        tick();
        store = '0;
        checks++; if (write !== 1'b0) begin errors++;
            $display("FAIL no_bypass: write=%b expected 0", write); end
        tick();
        checks++; if (write !== 1'b1 || select !== 2'd1 || wdata !== 32'h11111111) begin errors++;
            $display("FAIL first_grant: got w=%b s=%0d d=%h expected 1/1/11111111", write, select, wdata); end
        if (backpressure) begin
            mem_ready = 1'b0;
            for (int n = 0; n < 3; n++) begin
                tick();
                checks++; if (write !== 1'b1 || select !== 2'd1 || wdata !== 32'h11111111) begin errors++;
                    $display("FAIL hold%0d: got w=%b s=%0d d=%h expected 1/1/11111111", n, write, select, wdata); end
            end
            mem_ready = 1'b1;
        end
        tick();
        checks++; if (write !== 1'b1 || select !== 2'd2 || wdata !== 32'h22222222) begin errors++;
            $display("FAIL second_grant: got w=%b s=%0d d=%h expected 1/2/22222222", write, select, wdata); end
        tick();
        checks++; if (write !== 1'b0 || select !== 2'd0 || wdata !== 32'h22222222) begin errors++;
            $display("FAIL go_idle: got w=%b s=%0d d=%h expected 0/0/22222222", write, select, wdata); end
    endtask

    task automatic test_overflow;
        do_reset();
        for (int w = 1; w <= 6; w++) begin
            store = 3'b001; data_in = '0; data_in[DW-1:0] = DW'(w);
            tick();
            checks++; if (full[0] !== (w >= 5)) begin errors++;
                $display("FAIL full_after_push%0d: got %b expected %b", w, full[0], (w >= 5)); end
            checks++; if (overflow[0] !== (w == 6)) begin errors++;
                $display("FAIL ovf_after_push%0d: got %b expected %b", w, overflow[0], (w == 6)); end
        end
        store = '0;
        checks++; if (write !== 1'b1 || wdata !== 32'd1) begin errors++;
            $display("FAIL ovf_held_word: got w=%b d=%h expected 1/1", write, wdata); end
        mem_ready = 1'b1;
        for (int w = 2; w <= 5; w++) begin
            tick();
            checks++; if (write !== 1'b1 || wdata !== DW'(w) || overflow !== 3'b001) begin errors++;
                $display("FAIL drain%0d: got w=%b d=%h o=%b expected 1/%h/001", w, write, wdata, overflow, w); end
        end
        tick();
        checks++; if (write !== 1'b0 || full !== '0 || overflow !== 3'b001) begin errors++;
            $display("FAIL drain_end: got w=%b f=%b o=%b expected 0/000/001", write, full, overflow); end
    endtask

    task automatic preload;
        do_reset();
        store = 3'b111; load_words(0); tick();
        load_words(1); tick();
        store = '0;
    endtask

    task automatic test_fairness;
        int exp_sel;
        logic [DW-1:0] exp_dat;
        preload();
        checks++; if (write !== 1'b1 || select !== 2'd1 || wdata !== 32'h100) begin errors++;
            $display("FAIL fair_first: got s=%0d d=%h expected 1/100", select, wdata); end
        mem_ready = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            exp_sel = (k < 6) ? (k % NCH) + 1 : 0;
            exp_dat = (k < 6) ? 32'h100 * ((k % NCH) + 1) + (k / NCH) : 32'h301;
            checks++; if (select !== SW'(exp_sel) || write !== (k < 6) || wdata !== exp_dat) begin errors++;
                $display("FAIL fair_seq%0d: got w=%b s=%0d d=%h expected s=%0d d=%h", k, write, select, wdata, exp_sel, exp_dat); end
        end
    endtask

    task automatic test_reset_mid_drain;
        preload();
        mem_ready = 1'b1;
        tick(); tick();
        checks++; if (select !== 2'd3) begin errors++;
            $display("FAIL middrain_pre: got s=%0d expected 3", select); end
        #2 reset = 1'b1;
        #1;
        checks++; if ({write, select, wdata, full, overflow} !== '0) begin errors++;
            $display("FAIL middrain_reset: got w=%b s=%0d d=%h f=%b o=%b expected all 0", write, select, wdata, full, overflow); end
        @(negedge clk); reset = 1'b0;
        for (int n = 0; n < 3; n++) begin
            tick();
            checks++; if (write !== 1'b0 || select !== 2'd0) begin errors++;
                $display("FAIL middrain_after%0d: got w=%b s=%0d expected 0/0", n, write, select); end
        end
    endtask

    task automatic test_random;
        logic [DW-1:0] mq [NCH][$];
        bit            m_write;
        int            m_sel, m_rr, g, c, st_pct, rdy_pct;
        logic [DW-1:0] m_wdata, head;
        logic [NCH-1:0] m_ovf, m_full;
        bit            any, ld;
        do_reset();
        m_write = 0; m_sel = 0; m_rr = 0; m_wdata = '0; m_ovf = '0;
        for (int i = 0; i < NCH; i++) mq[i].delete();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            case ((cyc / 500) % 4)
                0: begin st_pct = 30;  rdy_pct = 90;  end
                1: begin st_pct = 80;  rdy_pct = 20;  end
                2: begin st_pct = 100; rdy_pct = 50;  end
                default: begin st_pct = 50; rdy_pct = 100; end
            endcase
            for (int i = 0; i < NCH; i++) begin
                store[i] = ($urandom_range(99) < st_pct);
                data_in[i*DW +: DW] = $urandom();
            end
            mem_ready = ($urandom_range(99) < rdy_pct);
            any = 0;
            for (int i = 0; i < NCH; i++) if (mq[i].size() > 0) any = 1;
            ld = (!m_write || mem_ready) && any;
            g = -1; head = '0;
            if (ld) begin
                for (int k = 0; k < NCH; k++) begin
                    c = (m_rr + k) % NCH;
                    if (g < 0 && mq[c].size() > 0) g = c;
                end
                head = mq[g].pop_front();
            end
            for (int i = 0; i < NCH; i++) begin
                if (store[i]) begin
                    if (mq[i].size() < DEP) mq[i].push_back(data_in[i*DW +: DW]);
                    else m_ovf[i] = 1'b1;
                end
            end
            if (ld) begin
                m_write = 1; m_sel = g + 1; m_wdata = head; m_rr = (g + 1) % NCH;
            end else if (m_write && mem_ready) begin
                m_write = 0; m_sel = 0;
            end
            for (int i = 0; i < NCH; i++) m_full[i] = (mq[i].size() == DEP);
            tick();
            checks++; if (write !== m_write || select !== SW'(m_sel)) begin errors++;
                $display("FAIL rnd_ctrl@%0d: got w=%b s=%0d expected w=%b s=%0d", cyc, write, select, m_write, m_sel); end
            checks++; if (wdata !== m_wdata) begin errors++;
                $display("FAIL rnd_wdata@%0d: got %h expected %h", cyc, wdata, m_wdata); end
            checks++; if (full !== m_full || overflow !== m_ovf) begin errors++;
                $display("FAIL rnd_flags@%0d: got f=%b o=%b expected f=%b o=%b", cyc, full, overflow, m_full, m_ovf); end
        end
    endtask

    initial begin
        test_reset();
        test_two_channel(1'b0);
        test_two_channel(1'b1);
        test_overflow();
        test_fairness();
        test_reset_mid_drain();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
